// File: rtl/imem_fetch_responder_if.sv
// rtl/imem_fetch_responder_if.sv - fetch request/response, flush and program-load bundle
interface imem_fetch_responder_if #(
    parameter int AW = 10
);
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [31:0]   rsp_addr;
    logic          rsp_err;
    logic          flush;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_byte;

    modport master (
        output req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_byte,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_byte,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - byte-wide instruction store answering 32-bit little-endian fetches
module imem_fetch_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_fetch_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t        state;
    logic [1:0]    cnt;
    logic [7:0]    mem [MEM_BYTES];
    logic [32:0]   last_byte;
    logic          range_err;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_byte;

    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign last_byte = {1'b0, bus.req_addr} + 33'd3;
    assign range_err = last_byte > 33'(MEM_BYTES - 1);
    assign rd_addr   = bus.rsp_addr[AW-1:0] + AW'(cnt);
    assign rd_byte   = mem[rd_addr];

    // Program store is never cleared; a same-edge read sees the old byte
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 32'd0;
            bus.rsp_addr  <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready && !bus.flush) begin
                        bus.req_ready <= 1'b0;
                        bus.rsp_addr  <= bus.req_addr;
                        bus.rsp_data  <= 32'd0;
                        cnt           <= 2'd0;
                        if (range_err) begin
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            bus.rsp_err <= 1'b0;
                            state       <= READ;
                        end
                    end
                end
                READ: begin
                    if (bus.flush) begin
                        state         <= IDLE;
                        cnt           <= 2'd0;
                        bus.req_ready <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                    end else begin
                        bus.rsp_data[8*cnt +: 8] <= rd_byte;
                        cnt                      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.flush) begin
                        state         <= IDLE;
                        cnt           <= 2'd0;
                        bus.req_ready <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    cnt           <= 2'd0;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder serving the fetch stage over a valid/ready request/response handshake.
- Holds a byte-addressed program store and assembles each 32-bit instruction little-endian from 4 consecutive bytes, one byte per cycle.
- A byte-wide write port loads the program before or during execution.
- A Flush input lets the fetch stage abort an in-flight fetch on a taken branch.

Parameters:
- MEM_BYTES, 1024, store depth in bytes; addresses 0..MEM_BYTES-1 are valid.
- AW, 10, internal byte-address width; must equal clog2(MEM_BYTES).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ReqValid  input  1  fetch request present.
- ReqAddr  input  32  byte address of the instruction (any alignment).
- ReqReady  output  1  responder can accept a request.
- RspValid  output  1  response present.
- RspReady  input  1  fetch stage accepts the response.
- RspData  output  32  instruction; byte i = Mem[addr+i].
- RspAddr  output  32  echo of the accepted ReqAddr.
- RspErr  output  1  address range fault.
- Flush  input  1  abort the current transaction.
- WrEn  input  1  program-load byte write.
- WrAddr  input  AW  write byte address.
- WrByte  input  8  write data.

Behaviour:
Reset (asynchronous):
- State goes to IDLE.
- ReqReady=0 while Reset is asserted; ReqReady=1 from the first edge after release.
- RspValid=0, RspData=0, RspAddr=0, RspErr=0, byte counter=0.
- Memory contents are not cleared.

States: IDLE, READ, RESP.
- IDLE:
  - ReqReady=1.
  - ReqValid&ReqReady at an edge latches ReqAddr into RspAddr and clears RspData.
  - Range check: if ReqAddr+3 > MEM_BYTES-1, computed in 33 bits so there is no wrap, go to RESP with RspErr=1 and RspData=0.
  - Otherwise go to READ with counter=0.
- READ:
  - ReqReady=0.
  - Each cycle: RspData[8*cnt +: 8] <= Mem[RspAddr[AW-1:0]+cnt], then cnt++.
  - After cnt=3 is written, go to RESP.
- RESP:
  - RspValid=1; RspData, RspAddr and RspErr are held stable while RspReady=0.
  - RspValid&RspReady at an edge: RspValid goes to 0 and the state returns to IDLE.
  - A new request is accepted no earlier than the following cycle; there is no same-cycle turnaround.

Latency:
- Request accepted at edge N.
- Bytes are read at edges N+1..N+4.
- RspValid=1 after edge N+4.
- Minimum period is 6 cycles per fetch with RspReady tied to 1.

Flush:
- Flush=1 at an edge in READ or RESP: go to IDLE, RspValid=0, RspErr=0, counter=0. No response is ever issued for the aborted request.
- Flush in IDLE: the request presented in that cycle is not accepted.
- Flush has priority over the handshake and over request acceptance.

Write port:
- Active in every state.
- Mem[WrAddr] <= WrByte at the edge.
- A READ that samples the same byte at the same edge gets the old value (read-before-write).

Further rules:
- Unaligned addresses are legal, with no fault.
- ReqAddr bits above AW are ignored only after the range check passes; in practice they are zero whenever the check passes.
- Reset asserted mid-READ or mid-RESP: outputs drop immediately to their reset values.
- Writes take effect independently of the fetch state.

Test Plan:
- Load Mem[0..3]=0x13,0x05,0xA0,0x00; request addr 0 with RspReady=1 → RspValid after 5 edges, RspData=0x00A00513, RspAddr=0, RspErr=0.
- Unaligned request addr 1 with Mem[4]=0x7F → RspData=0x7F00A005.
- Request addr MEM_BYTES-3 (1021) → RESP on the next edge with RspErr=1, RspData=0. Request addr 0xFFFFFFFE → RspErr=1, no wrap.
- Hold RspReady=0 for 5 cycles in RESP → RspValid, RspData and RspAddr remain stable and ReqReady=0; RspReady=1 → accepted, ReqReady=1 the next cycle.
- Flush at the 2nd READ edge → RspValid never rises for that request. An immediate new request to addr 4 returns the correct word with no stale bytes from the aborted read.
- Assert Reset during READ → all outputs reach reset values without a clock edge; after release a fetch of addr 0 completes normally and memory is intact.
- Write Mem[2]=0xEE on the same edge READ samples byte 2 → the response carries the old byte. A repeat fetch returns 0xEE in bits 23:16.
